// File: rtl/ks_pkg.sv
// Shared widths, key-width code type and controller state encoding
// for the key-schedule sharing controller.
package ks_pkg;

  localparam int KWIDTHMAX_DEF = 256;
  localparam int CWIDTH_DEF    = 192;
  localparam int XWIDTH_DEF    = 64;

  typedef logic [1:0] kwidth_t;

  localparam kwidth_t KW_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    START,
    BUSY,
    RESP
  } ks_sched_state_t;

endpackage

// File: rtl/ks_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after ptr_i.
// Ports: req_i (requests), ptr_i (last winner), en_i, gnt_o (one-hot), gnt_id_o.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_id_o
);

  logic [IDW-1:0] idx;
  logic           found;

  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    idx      = '0;
    found    = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(ptr_i) + k) % NREQ);
      if (en_i && !found && req_i[idx]) begin
        found       = 1'b1;
        gnt_o[idx]  = 1'b1;
        gnt_id_o    = idx;
      end
    end
  end

endmodule

// File: rtl/ks_sched.sv
// Shares one key-schedule engine between NREQ cores: round-robin accept,
// start pulse, capture on done edge, tagged response. Optional macro:
// KS_SCHED_CACHE_EN adds a single-entry result cache.
// Ports: req_* (requests), rsp_* (responses), ks_* (engine side).
module ks_sched
  import ks_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int KWIDTHMAX = KWIDTHMAX_DEF,
  parameter int CWIDTH    = CWIDTH_DEF,
  parameter int XWIDTH    = XWIDTH_DEF,
  parameter int IDW       = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*KWIDTHMAX-1:0] req_key,
  input  logic [NREQ*2-1:0]         req_kwidth,
  output logic [NREQ-1:0]           req_ready,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [IDW-1:0]            rsp_id,
  output logic                      rsp_err,
  output logic [CWIDTH-1:0]         rsp_cout,
  output logic [XWIDTH-1:0]         rsp_xout,
  output logic [KWIDTHMAX-1:0]      ks_k,
  output logic [1:0]                ks_kWidth,
  output logic                      ks_start,
  input  logic                      ks_done,
  input  logic [CWIDTH-1:0]         ks_cout,
  input  logic [XWIDTH-1:0]         ks_xout
);

  ks_sched_state_t state_q, state_d;

  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [KWIDTHMAX-1:0] key_q, key_d;
  kwidth_t              kw_q, kw_d;
  logic [IDW-1:0]       id_q, id_d;
  logic                 err_q, err_d;
  logic [CWIDTH-1:0]    cout_q, cout_d;
  logic [XWIDTH-1:0]    xout_q, xout_d;
  logic                 done_q;

  logic [NREQ-1:0]      gnt;
  logic [IDW-1:0]       gnt_id;
  logic                 arb_en;
  logic [KWIDTHMAX-1:0] g_key;
  kwidth_t              g_kw;
  logic                 cap;
  logic                 hit;
  logic [CWIDTH-1:0]    hit_cout;
  logic [XWIDTH-1:0]    hit_xout;

  // Reset is folded in so the combinational grant is also 0 in reset.
  assign arb_en = (state_q == IDLE) && reset;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_i    (req_valid),
    .ptr_i    (rr_ptr_q),
    .en_i     (arb_en),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  always_comb begin
    g_key = '0;
    g_kw  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        g_key = req_key[i*KWIDTHMAX +: KWIDTHMAX];
        g_kw  = req_kwidth[i*2 +: 2];
      end
    end
  end

  // A done level already high on BUSY entry is not an edge.
  assign cap = (state_q == BUSY) && ks_done && !done_q;

`ifdef KS_SCHED_CACHE_EN
  logic                 c_vld_q;
  logic [KWIDTHMAX-1:0] c_key_q;
  kwidth_t              c_kw_q;
  logic [CWIDTH-1:0]    c_cout_q;
  logic [XWIDTH-1:0]    c_xout_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_vld_q  <= 1'b0;
      c_key_q  <= '0;
      c_kw_q   <= '0;
      c_cout_q <= '0;
      c_xout_q <= '0;
    end else if (cap) begin
      c_vld_q  <= 1'b1;
      c_key_q  <= key_q;
      c_kw_q   <= kw_q;
      c_cout_q <= ks_cout;
      c_xout_q <= ks_xout;
    end
  end

  assign hit = c_vld_q && (c_key_q == g_key)
               && (c_kw_q == g_kw);
  assign hit_cout = c_cout_q;
  assign hit_xout = c_xout_q;
`else
  assign hit      = 1'b0;
  assign hit_cout = '0;
  assign hit_xout = '0;
`endif

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    key_d    = key_q;
    kw_d     = kw_q;
    id_d     = id_q;
    err_d    = err_q;
    cout_d   = cout_q;
    xout_d   = xout_q;
    unique case (state_q)
      IDLE: begin
        if (|gnt) begin
          rr_ptr_d = gnt_id;
          key_d    = g_key;
          kw_d     = g_kw;
          id_d     = gnt_id;
          if (g_kw == KW_RSVD) begin
            err_d   = 1'b1;
            cout_d  = '0;
            xout_d  = '0;
            state_d = RESP;
          end else if (hit) begin
            err_d   = 1'b0;
            cout_d  = hit_cout;
            xout_d  = hit_xout;
            state_d = RESP;
          end else begin
            state_d = START;
          end
        end
      end
      START: state_d = BUSY;
      BUSY: begin
        if (cap) begin
          err_d   = 1'b0;
          cout_d  = ks_cout;
          xout_d  = ks_xout;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= IDW'(NREQ - 1);
      key_q    <= '0;
      kw_q     <= '0;
      id_q     <= '0;
      err_q    <= 1'b0;
      cout_q   <= '0;
      xout_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      key_q    <= key_d;
      kw_q     <= kw_d;
      id_q     <= id_d;
      err_q    <= err_d;
      cout_q   <= cout_d;
      xout_q   <= xout_d;
      done_q   <= ks_done;
    end
  end

  assign req_ready = gnt;
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_err   = err_q;
  assign rsp_cout  = cout_q;
  assign rsp_xout  = xout_q;
  assign ks_k      = key_q;
  assign ks_kWidth = kw_q;
  assign ks_start  = (state_q == START);

endmodule
